// File: rtl/sfi_pkg.sv
// Shared types and constants for the SFI commit-record rewrite stream.
package sfi_pkg;
  localparam int          SFI_W     = 64;
  localparam int          SFI_CNT_W = 32;
  localparam int          OP_LSB    = 26;
  localparam int          OP_SB     = 40;
  localparam int          OP_SW     = 43;
  localparam logic [63:0] MASK_RST  = 64'h00FF_FFFF_FFFF_FFFF;
  localparam logic [63:0] TAG_RST   = 64'hA200_0000_0000_0000;

  localparam logic [1:0] CFG_MASK = 2'd0;
  localparam logic [1:0] CFG_TAG  = 2'd1;
  localparam logic [1:0] CFG_CTRL = 2'd2;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ACTIVE   = 2'd1,
    ST_DRAIN    = 2'd2
  } state_e;
endpackage

// File: rtl/sfi_stream_ctrl_rewrite.sv
// Combinational store detect, sandbox rewrite and out-of-sandbox check.
module sfi_rewrite #(
  parameter int W      = 64,
  parameter int OP_LSB = 26,
  parameter int OP_SB  = 40,
  parameter int OP_SW  = 43
) (
  input  logic [W-1:0] rec,
  input  logic [W-1:0] mask,
  input  logic [W-1:0] tag,
  output logic         is_st,
  output logic [W-1:0] rw_data,
  output logic         viol
);
  localparam logic [5:0] SB = OP_SB[5:0];
  localparam logic [5:0] SW = OP_SW[5:0];

  logic [5:0] op;

  assign op      = rec[OP_LSB+5:OP_LSB];
  assign is_st   = (op == SB) || (op == SW);
  assign rw_data = (rec & mask) | tag;
  // Address bits outside the sandbox must already equal the tag.
  assign viol    = (rec & ~mask) != tag;
endmodule

// File: rtl/sfi_stream_ctrl.sv
// SFI stream controller: config regs, enable/drain FSM, one-stage pipe, stats.
module sfi_stream_ctrl
  import sfi_pkg::*;
#(
  parameter int          W        = sfi_pkg::SFI_W,
  parameter int          CNT_W    = sfi_pkg::SFI_CNT_W,
  parameter logic [63:0] MASK_INIT = sfi_pkg::MASK_RST,
  parameter logic [63:0] TAG_INIT  = sfi_pkg::TAG_RST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [W-1:0]     cfg_wdata,
  output logic             cfg_err,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] rewrite_cnt,
  output logic [CNT_W-1:0] viol_cnt
);
  state_e           state_q, state_d;
  logic             pv_q, pv_d;
  logic [W-1:0]     pd_q, pd_d;
  logic [W-1:0]     mask_q, mask_d, tag_q, tag_d;
  logic [CNT_W-1:0] rw_cnt_q, rw_cnt_d, viol_cnt_q, viol_cnt_d;
  logic             cfg_err_q, cfg_err_d;

  logic         is_st, viol, xfer, do_rw, ctrl_wr;
  logic [W-1:0] rw_data;

  sfi_rewrite #(.W(W), .OP_LSB(OP_LSB), .OP_SB(OP_SB), .OP_SW(OP_SW)) u_rw (
    .rec(in_data), .mask(mask_q), .tag(tag_q),
    .is_st(is_st), .rw_data(rw_data), .viol(viol)
  );

  assign in_ready = (state_q != ST_DRAIN) && (!pv_q || out_ready);
  assign xfer     = in_valid && in_ready;
  assign do_rw    = xfer && is_st && (state_q == ST_ACTIVE);
  assign ctrl_wr  = cfg_we && (cfg_addr == CFG_CTRL);

  assign out_valid   = pv_q;
  assign out_data    = pd_q;
  assign cfg_err     = cfg_err_q;
  assign state_o     = state_q;
  assign rewrite_cnt = rw_cnt_q;
  assign viol_cnt    = viol_cnt_q;

  always_comb begin
    pv_d = pv_q;
    pd_d = pd_q;
    if (xfer) begin
      pv_d = 1'b1;
      pd_d = do_rw ? rw_data : in_data;
    end else if (out_ready) begin
      pv_d = 1'b0;
    end

    rw_cnt_d   = rw_cnt_q;
    viol_cnt_d = viol_cnt_q;
    if (do_rw) begin
      if (rw_cnt_q != '1) rw_cnt_d = rw_cnt_q + 1'b1;
      if (viol && viol_cnt_q != '1) viol_cnt_d = viol_cnt_q + 1'b1;
    end
    // Clear overrides any increment from a capture in the same cycle.
    if (ctrl_wr && cfg_wdata[1]) begin
      rw_cnt_d   = '0;
      viol_cnt_d = '0;
    end

    mask_d    = mask_q;
    tag_d     = tag_q;
    cfg_err_d = 1'b0;
    if (cfg_we) begin
      case (cfg_addr)
        CFG_MASK: if (state_q == ST_DISABLED) mask_d = cfg_wdata; else cfg_err_d = 1'b1;
        CFG_TAG:  if (state_q == ST_DISABLED) tag_d  = cfg_wdata; else cfg_err_d = 1'b1;
        CFG_CTRL: ;
        default:  cfg_err_d = 1'b1;
      endcase
    end

    state_d = state_q;
    case (state_q)
      ST_DISABLED: if (ctrl_wr && cfg_wdata[0])  state_d = ST_ACTIVE;
      ST_ACTIVE:   if (ctrl_wr && !cfg_wdata[0]) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (ctrl_wr && cfg_wdata[0]) state_d = ST_ACTIVE;
        else if (!pv_q)              state_d = ST_DISABLED;
      end
      default: state_d = ST_DISABLED;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_DISABLED;
      pv_q       <= 1'b0;
      pd_q       <= '0;
      mask_q     <= MASK_INIT[W-1:0];
      tag_q      <= TAG_INIT[W-1:0];
      rw_cnt_q   <= '0;
      viol_cnt_q <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pv_q       <= pv_d;
      pd_q       <= pd_d;
      mask_q     <= mask_d;
      tag_q      <= tag_d;
      rw_cnt_q   <= rw_cnt_d;
      viol_cnt_q <= viol_cnt_d;
      cfg_err_q  <= cfg_err_d;
    end
  end
endmodule

// File: tb/tb_sfi_stream_ctrl.sv
// Scoreboard bench for sfi_stream_ctrl: model predicts each captured record.
module tb_sfi_stream_ctrl;
  localparam logic [63:0] MASK_D = 64'h00FF_FFFF_FFFF_FFFF;
  localparam logic [63:0] TAG_D  = 64'hA200_0000_0000_0000;

  logic        clk = 0, rst = 1;
  logic        in_valid = 0, in_ready, out_valid, out_ready = 0;
  logic [63:0] in_data = '0, out_data, cfg_wdata = '0;
  logic        cfg_we = 0, cfg_err;
  logic [1:0]  cfg_addr = '0, state_o;
  logic [31:0] rewrite_cnt, viol_cnt;

  int errors = 0, checks = 0;
  logic [63:0] exp_q[$];
  bit          m_active = 0;
  logic [63:0] m_mask = MASK_D, m_tag = TAG_D;
  int          m_rw = 0, m_viol = 0;

  sfi_stream_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_err(cfg_err),
    .state_o(state_o), .rewrite_cnt(rewrite_cnt), .viol_cnt(viol_cnt)
  );

  always #5 clk = ~clk;

  // Inputs change at posedge+1, so negedge values describe the coming edge.
  always @(negedge clk) begin
    logic [63:0] e;
    logic [5:0]  op;
    if (!rst) begin
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL out_unexpected got=%h", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin
            errors++; $display("FAIL out_data got=%h exp=%h", out_data, e);
          end
        end
      end
      if (in_valid && in_ready) begin
        op = in_data[31:26];
        if (m_active && (op == 6'd40 || op == 6'd43)) begin
          e = (in_data & m_mask) | m_tag;
          m_rw++;
          if ((in_data & ~m_mask) != m_tag) m_viol++;
        end else e = in_data;
        exp_q.push_back(e);
      end
      if (cfg_we && cfg_addr == 2'd2) begin
        m_active = cfg_wdata[0];
        if (cfg_wdata[1]) begin m_rw = 0; m_viol = 0; end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [63:0] d);
    bit hs = 0;
    int n = 0;
    in_valid = 1; in_data = d;
    while (!hs && n < 50) begin
      @(negedge clk); hs = in_ready;
      cyc(); n++;
    end
    in_valid = 0; in_data = '0;
    checks++;
    if (!hs) begin errors++; $display("FAIL send_timeout data=%h", d); end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [63:0] d);
    cfg_we = 1; cfg_addr = a; cfg_wdata = d;
    cyc();
    cfg_we = 0; cfg_wdata = '0;
  endtask

  task automatic wait_empty(input string tag);
    int n = 0;
    out_ready = 1;
    while ((exp_q.size() != 0 || out_valid) && n < 50) begin cyc(); n++; end
    checks++;
    if (exp_q.size() != 0 || out_valid) begin
      errors++; $display("FAIL %s_drain left=%0d exp=0", tag, exp_q.size());
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input string tag);
    int n = 0;
    while (state_o !== s && n < 10) begin cyc(); n++; end
    checks++;
    if (state_o !== s) begin errors++; $display("FAIL %s got=%0d exp=%0d", tag, state_o, s); end
  endtask

  task automatic test_reset();
    rst = 1; #3;
    checks += 5;
    if (out_valid !== 1'b0)   begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    if (out_data !== 64'h0)   begin errors++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
    if (state_o !== 2'd0)     begin errors++; $display("FAIL rst_state got=%0d exp=0", state_o); end
    if (rewrite_cnt !== 0 || viol_cnt !== 0) begin
      errors++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", rewrite_cnt, viol_cnt);
    end
    if (cfg_err !== 1'b0)     begin errors++; $display("FAIL rst_cfg_err got=%b exp=0", cfg_err); end
    cyc(); cyc(); rst = 0; cyc();
  endtask

  task automatic test_disabled_pass();
    out_ready = 1;
    send(64'h0000_0000_AC00_1000);
    checks += 2;
    if (out_valid !== 1'b1 || out_data !== 64'h0000_0000_AC00_1000) begin
      errors++; $display("FAIL dis_pass got=%b/%h exp=1/%h", out_valid, out_data, 64'h0000_0000_AC00_1000);
    end
    cyc();
    if (rewrite_cnt !== 0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL dis_cnt got=%0d/%b exp=0/0", rewrite_cnt, out_valid);
    end
  endtask

  task automatic test_rewrite();
    cfg_write(2'd2, 64'd1);
    checks++;
    if (state_o !== 2'd1) begin errors++; $display("FAIL act_state got=%0d exp=1", state_o); end
    send(64'h1234_5678_AC00_1000);
    checks += 2;
    if (out_data !== 64'hA234_5678_AC00_1000) begin
      errors++; $display("FAIL rw_data got=%h exp=%h", out_data, 64'hA234_5678_AC00_1000);
    end
    if (rewrite_cnt !== 1 || viol_cnt !== 1) begin
      errors++; $display("FAIL rw_cnt got=%0d/%0d exp=1/1", rewrite_cnt, viol_cnt);
    end
    send(64'hA200_0000_A000_0004);
    checks += 2;
    if (out_data !== 64'hA200_0000_A000_0004) begin
      errors++; $display("FAIL rw_inbox got=%h exp=%h", out_data, 64'hA200_0000_A000_0004);
    end
    if (rewrite_cnt !== 2 || viol_cnt !== 1) begin
      errors++; $display("FAIL rw_inbox_cnt got=%0d/%0d exp=2/1", rewrite_cnt, viol_cnt);
    end
  endtask

  task automatic test_non_store();
    send(64'h1234_5678_8C00_0000);
    checks += 2;
    if (out_data !== 64'h1234_5678_8C00_0000) begin
      errors++; $display("FAIL nst_data got=%h exp=%h", out_data, 64'h1234_5678_8C00_0000);
    end
    if (rewrite_cnt !== 2 || viol_cnt !== 1) begin
      errors++; $display("FAIL nst_cnt got=%0d/%0d exp=2/1", rewrite_cnt, viol_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] recs[6] = '{64'h1111_0000_AC00_0001, 64'h2222_0000_8C00_0002,
                             64'hA200_0000_A000_0003, 64'h3333_0000_AC00_0004,
                             64'h4444_0000_0000_0005, 64'h5555_0000_A000_0006};
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int sent = 0;
    bit stalled = 0, hs;
    logic [63:0] held = '0;
    in_valid = 1; in_data = recs[0];
    for (int c = 0; c < 60 && sent < 6; c++) begin
      out_ready = pat[c % 4];
      @(negedge clk);
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          errors++; $display("FAIL b2b_stable got=%h exp=%h", out_data, held);
        end
      end
      stalled = out_valid && !out_ready;
      held = out_data;
      hs = in_ready;
      cyc();
      if (hs) begin
        sent++;
        if (sent < 6) in_data = recs[sent]; else begin in_valid = 0; in_data = '0; end
      end
    end
    in_valid = 0;
    checks++;
    if (sent != 6) begin errors++; $display("FAIL b2b_sent got=%0d exp=6", sent); end
    wait_empty("b2b");
    checks++;
    if (rewrite_cnt !== m_rw || viol_cnt !== m_viol) begin
      errors++; $display("FAIL b2b_cnt got=%0d/%0d exp=%0d/%0d", rewrite_cnt, viol_cnt, m_rw, m_viol);
    end
  endtask

  task automatic test_drain();
    out_ready = 0;
    send(64'h6666_0000_AC00_0007);
    cfg_write(2'd2, 64'd0);
    checks += 2;
    if (state_o !== 2'd2) begin errors++; $display("FAIL drn_state got=%0d exp=2", state_o); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL drn_in_ready got=%b exp=0", in_ready); end
    cfg_write(2'd0, 64'h0);
    checks += 2;
    if (cfg_err !== 1'b1) begin errors++; $display("FAIL drn_cfg_err got=%b exp=1", cfg_err); end
    cyc();
    if (cfg_err !== 1'b0 || state_o !== 2'd2) begin
      errors++; $display("FAIL drn_err_pulse got=%b/%0d exp=0/2", cfg_err, state_o);
    end
    out_ready = 1;
    wait_empty("drn");
    wait_state(2'd0, "drn_to_dis");
    cfg_write(2'd3, 64'hFFFF);
    checks++;
    if (cfg_err !== 1'b1) begin errors++; $display("FAIL addr3_err got=%b exp=1", cfg_err); end
    cfg_write(2'd2, 64'd1);
    send(64'h0000_0000_AC00_1000);
    checks++;
    if (out_data !== 64'hA200_0000_AC00_1000) begin
      errors++; $display("FAIL mask_kept got=%h exp=%h", out_data, 64'hA200_0000_AC00_1000);
    end
    wait_empty("drn2");
  endtask

  task automatic test_reset_and_clear();
    cfg_write(2'd2, 64'd0);
    wait_state(2'd0, "rc_dis");
    cfg_write(2'd0, 64'h0000_FFFF_FFFF_FFFF); m_mask = 64'h0000_FFFF_FFFF_FFFF;
    cfg_write(2'd1, 64'h5500_0000_0000_0000); m_tag  = 64'h5500_0000_0000_0000;
    cfg_write(2'd2, 64'd1);
    out_ready = 0;
    send(64'h1234_5678_AC00_1000);
    rst = 1; #1;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_async got=%b exp=0", out_valid); end
    if (state_o !== 2'd0 || rewrite_cnt !== 0 || viol_cnt !== 0) begin
      errors++; $display("FAIL rst_mid got=%0d/%0d/%0d exp=0/0/0", state_o, rewrite_cnt, viol_cnt);
    end
    exp_q.delete();
    m_active = 0; m_mask = MASK_D; m_tag = TAG_D; m_rw = 0; m_viol = 0;
    cyc(); rst = 0; cyc();
    out_ready = 1;
    cfg_write(2'd2, 64'd1);
    send(64'h1234_5678_AC00_1000);
    checks++;
    if (out_data !== 64'hA234_5678_AC00_1000) begin
      errors++; $display("FAIL rst_defaults got=%h exp=%h", out_data, 64'hA234_5678_AC00_1000);
    end
    in_valid = 1; in_data = 64'h7777_0000_AC00_0008;
    cfg_we = 1; cfg_addr = 2'd2; cfg_wdata = 64'd3;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL clr_in_ready got=%b exp=1", in_ready); end
    cyc();
    in_valid = 0; in_data = '0; cfg_we = 0; cfg_wdata = '0;
    checks++;
    if (rewrite_cnt !== 0 || viol_cnt !== 0) begin
      errors++; $display("FAIL clr_wins got=%0d/%0d exp=0/0", rewrite_cnt, viol_cnt);
    end
    send(64'h8888_0000_A000_0009);
    checks++;
    if (rewrite_cnt !== 1 || viol_cnt !== 1) begin
      errors++; $display("FAIL clr_after got=%0d/%0d exp=1/1", rewrite_cnt, viol_cnt);
    end
    wait_empty("rc");
  endtask

  initial begin
    test_reset();
    test_disabled_pass();
    test_rewrite();
    test_non_store();
    test_back_to_back();
    test_drain();
    test_reset_and_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
